// File: rtl/hot_addr_reader.sv
// hot_addr_reader: issues periodic or software-triggered queries to the hot
// tracker, collects the migration address beats that follow, and buffers them
// in a first-word fall-through FIFO that the CSR side pops.
module hot_addr_reader #(
  parameter int ADDR_SIZE = 33,
  parameter int DEPTH     = 16,
  parameter int NUM_ENTRY = 25,
  parameter int TIMEOUT   = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              csr_query_interval,
  input  logic                     csr_query_now,
  output logic                     query_en,
  input  logic                     query_ready,
  input  logic                     mig_addr_en,
  input  logic [ADDR_SIZE-1:0]     mig_addr,
  output logic                     mig_addr_ready,
  input  logic                     rd_req,
  output logic                     rd_valid,
  output logic [ADDR_SIZE-1:0]     rd_data,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [15:0]              drop_cnt,
  output logic [15:0]              query_cnt,
  output logic                     busy
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = $clog2(NUM_ENTRY + 1);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_COLLECT = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 query_en_q, query_en_d;
  logic [31:0]          ival_q, ival_d;
  logic                 pend_q, pend_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [TMR_W-1:0]     idle_q, idle_d;
  logic [15:0]          qcnt_q, qcnt_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [15:0]          drop_q, drop_d;
  logic [ADDR_SIZE-1:0] mem_q [DEPTH];

  logic push_s, pop_s, full_s, wr_s, drop_s;

  // Beats are accepted unconditionally outside reset; overflow is handled by
  // dropping, never by back-pressure.
  assign mig_addr_ready = ~rst;

  assign push_s = mig_addr_en & mig_addr_ready;
  assign full_s = (count_q == CNT_W'(DEPTH));
  assign pop_s  = rd_req & (count_q != CNT_W'(0));
  assign wr_s   = push_s & (~full_s | pop_s);
  assign drop_s = push_s & full_s & ~pop_s;

  // Query/collect FSM next-state, interval timer, pending trigger and round counters.
  always_comb begin
    state_d = state_q;
    ival_d  = ival_q;
    pend_d  = pend_q;
    beat_d  = BEAT_W'(0);
    idle_d  = TMR_W'(0);
    qcnt_d  = qcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (csr_query_now || pend_q ||
            ((csr_query_interval != 32'd0) && (ival_q == 32'd1))) begin
          state_d = ST_REQ;
          ival_d  = csr_query_interval;
          pend_d  = 1'b0;
        end else if (csr_query_interval == 32'd0) begin
          ival_d = csr_query_interval;
        end else if (ival_q == 32'd0) begin
          // interval was just enabled from 0: start a full period
          ival_d = csr_query_interval;
        end else begin
          ival_d = ival_q - 32'd1;
        end
      end
      ST_REQ: begin
        if (csr_query_now) begin
          pend_d = 1'b1;
        end else begin
          pend_d = pend_q;
        end
        if (query_en_q && query_ready) begin
          state_d = ST_COLLECT;
          qcnt_d  = qcnt_q + 16'd1;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_COLLECT: begin
        if (csr_query_now) begin
          pend_d = 1'b1;
        end else begin
          pend_d = pend_q;
        end
        if ((beat_q == BEAT_W'(NUM_ENTRY)) || (idle_q == TMR_W'(TIMEOUT))) begin
          state_d = ST_IDLE;
        end else if (push_s) begin
          beat_d = beat_q + BEAT_W'(1);
          idle_d = TMR_W'(0);
        end else begin
          beat_d = beat_q;
          idle_d = idle_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (csr_query_interval == 32'd0) begin
      ival_d = 32'd0;
    end else begin
      ival_d = ival_d;
    end
    query_en_d = (state_d == ST_REQ);
  end

  // FIFO pointer, occupancy and drop-counter next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    drop_d   = drop_q;
    if (wr_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (drop_s && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end else begin
      drop_d = drop_q;
    end
    count_d = count_q + CNT_W'(wr_s) - CNT_W'(pop_s);
  end

  // State and counter registers; reset also discards buffered entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      query_en_q <= 1'b0;
      ival_q     <= csr_query_interval;
      pend_q     <= 1'b0;
      beat_q     <= BEAT_W'(0);
      idle_q     <= TMR_W'(0);
      qcnt_q     <= 16'd0;
      wr_ptr_q   <= PTR_W'(0);
      rd_ptr_q   <= PTR_W'(0);
      count_q    <= CNT_W'(0);
      drop_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      query_en_q <= query_en_d;
      ival_q     <= ival_d;
      pend_q     <= pend_d;
      beat_q     <= beat_d;
      idle_q     <= idle_d;
      qcnt_q     <= qcnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
    end
  end

  // Buffer storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_q[wr_ptr_q] <= mig_addr;
    end
  end

  assign query_en   = query_en_q;
  assign query_cnt  = qcnt_q;
  assign busy       = (state_q != ST_IDLE);
  assign rd_valid   = (count_q != CNT_W'(0));
  assign rd_data    = mem_q[rd_ptr_q];
  assign fill_level = count_q;
  assign drop_cnt   = drop_q;

endmodule

// File: doc/hot_addr_reader.md
HOT_ADDR_READER -- requirements
Module: hot_addr_reader

Interface
REQ-001 Parameter: ADDR_SIZE, 33, width of a migration address beat.
REQ-002 Parameter: DEPTH, 16, hot-address buffer entries (power of 2).
REQ-003 Parameter: NUM_ENTRY, 25, beats expected per query round.
REQ-004 Parameter: TIMEOUT, 64, idle cycles that end a collect round early.
REQ-005 Port: clk  in  1  sole clock; all logic on rising edge.
REQ-006 Port: rst  in  1  reset; synchronous, active-high.
REQ-007 Port: csr_query_interval  in  32  cycles between automatic queries; 0 disables automatic queries.
REQ-008 Port: csr_query_now  in  1  one-cycle software trigger for an immediate query.
REQ-009 Port: query_en  out  1  query request to the hot tracker.
REQ-010 Port: query_ready  in  1  hot tracker accepts query when high with query_en.
REQ-011 Port: mig_addr_en  in  1  migration address beat valid.
REQ-012 Port: mig_addr  in  ADDR_SIZE  migration address payload.
REQ-013 Port: mig_addr_ready  out  1  beat accept.
REQ-014 Port: rd_req  in  1  pop request from CSR side.
REQ-015 Port: rd_valid  out  1  buffer non-empty.
REQ-016 Port: rd_data  out  ADDR_SIZE  head-of-buffer address (first-word fall-through).
REQ-017 Port: fill_level  out  $clog2(DEPTH)+1  current entry count.
REQ-018 Port: drop_cnt  out  16  saturating count of beats lost to a full buffer.
REQ-019 Port: query_cnt  out  16  wrapping count of completed query handshakes.
REQ-020 Port: busy  out  1  high whenever state is not IDLE.

Function
REQ-021 FSM states IDLE, REQ, COLLECT; 2-bit encoding, registered.
REQ-022 IDLE: interval counter decrements each cycle while csr_query_interval != 0; transition to REQ when counter reaches 1, or when csr_query_now or pending-trigger flag is set.
REQ-023 Interval counter reloads with csr_query_interval on every exit from IDLE and whenever csr_query_interval is 0.
REQ-024 csr_query_now asserted outside IDLE sets pending-trigger flag; flag clears on entry to REQ; multiple triggers coalesce into one.
REQ-025 REQ: query_en held high, registered, until cycle with query_en & query_ready; that cycle query_cnt increments and next state is COLLECT; query_en low in the following cycle.
REQ-026 COLLECT: beat counter and idle timer start at 0 on entry; beat counter increments per accepted beat; idle timer clears on accepted beat, else increments.
REQ-027 COLLECT exits to IDLE the cycle after beat counter reaches NUM_ENTRY or idle timer reaches TIMEOUT, whichever first.
REQ-028 mig_addr_ready is 1 in every state when rst is low; beats arriving in IDLE or REQ are handled identically to COLLECT beats but do not affect the beat counter.
REQ-029 Accepted beat (mig_addr_en & mig_addr_ready) is written to buffer if not full; written entry visible on rd_data no earlier than the next cycle.
REQ-030 Beat arriving with buffer full and no pop in the same cycle is discarded; drop_cnt increments, saturating at 16'hFFFF.
REQ-031 Simultaneous push and pop with buffer full: pop frees head, push is stored, no drop, fill_level unchanged.
REQ-032 Simultaneous push and pop with buffer empty: pop ignored, push stored, fill_level becomes 1.
REQ-033 rd_req with rd_valid low is ignored; no pointer or count change.
REQ-034 Read/write pointers wrap modulo DEPTH; fill_level ranges 0..DEPTH.
REQ-035 query_cnt wraps from 16'hFFFF to 0.

Reset
REQ-036 While rst is high: state IDLE, query_en 0, mig_addr_ready 0, rd_valid 0, fill_level 0, drop_cnt 0, query_cnt 0, busy 0, pending flag 0, pointers 0, interval counter loaded with csr_query_interval.
REQ-037 rst asserted mid-round (REQ or COLLECT) aborts the round; buffer contents discarded; after rst release state is IDLE and no query_en is issued until the next trigger.

Verification
REQ-038 csr_query_interval=100, query_ready tied 1 -> query_en pulses 1 cycle, first at cycle 100 after rst release, then every 100 cycles plus round length; query_cnt counts 1,2,3.
REQ-039 csr_query_now pulse, query_ready low 5 cycles then high -> query_en high 6 cycles, busy high, COLLECT entered, query_cnt=1.
REQ-040 After query, send 25 beats addresses 0x100..0x118 back-to-back, no pops -> 16 stored (0x100..0x10F), drop_cnt=9, fill_level=16, state IDLE after 25th beat.
REQ-041 Buffer full, push 0x1AA and rd_req same cycle -> rd_data changes from 0x100 to 0x101, fill_level stays 16, drop_cnt unchanged, 0x1AA read last.
REQ-042 After query, send 3 beats then silence -> state returns IDLE exactly TIMEOUT=64 cycles after last beat plus 1; fill_level=3.
REQ-043 rst during COLLECT with fill_level=5 -> all outputs at reset values next cycle; rd_req ignored; no query_en until csr_query_now.
